// File: rtl/seq_lock_fsm.sv
// Switch-sequence lock: matches discrete one-hot presses against a programmable
// code, with an entry timeout, failure counting and a timed lockout.
module seq_lock_fsm #(
  parameter int unsigned NUM_SW         = 4,
  parameter int unsigned SEQ_LEN        = 4,
  parameter logic [SEQ_LEN*$clog2(NUM_SW)-1:0] DEFAULT_CODE = 8'b11_01_10_00,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned LOCKOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SW-1:0]                  sw,
  input  logic                               relock,
  input  logic                               code_wr,
  input  logic [SEQ_LEN*$clog2(NUM_SW)-1:0]  code_in,
  output logic [2:0]                         state,
  output logic [1:0]                         z,
  output logic [$clog2(SEQ_LEN+1)-1:0]       step,
  output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt
);

  localparam int unsigned IDX_W   = $clog2(NUM_SW);
  localparam int unsigned STEP_W  = $clog2(SEQ_LEN + 1);
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int unsigned CODE_W  = SEQ_LEN * IDX_W;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES
                                                                       : LOCKOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    ENTRY    = 3'b001,
    UNLOCKED = 3'b010,
    FAIL     = 3'b011,
    LOCKOUT  = 3'b100
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          z_q, z_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [NUM_SW-1:0]   sw_q;

  logic                press;
  logic                correct;
  logic [IDX_W-1:0]    press_idx;
  logic [IDX_W-1:0]    entry;

  assign press = (sw != '0) && (sw_q == '0);

  always_comb begin
    press_idx = '0;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      if (sw[i]) press_idx = IDX_W'(i);
    end
  end

  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      if (step_q == STEP_W'(i)) entry = code_q[i*IDX_W +: IDX_W];
    end
  end

  // press_idx is always < NUM_SW, so out-of-range code entries never match
  assign correct = press && $onehot(sw) && (press_idx == entry);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        step_d = '0;
        if (press) begin
          if (!correct) begin
            state_d = FAIL;
          end else if (SEQ_LEN == 1) begin
            state_d = UNLOCKED;
            fail_d  = '0;
          end else begin
            state_d = ENTRY;
            step_d  = STEP_W'(1);
          end
        end
      end
      ENTRY: begin
        if (press) begin
          cnt_d = '0;
          if (!correct) begin
            state_d = FAIL;
            step_d  = '0;
          end else if (step_q == STEP_W'(SEQ_LEN - 1)) begin
            state_d = UNLOCKED;
            step_d  = '0;
            fail_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          step_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FAIL: begin
        step_d = '0;
        cnt_d  = '0;
        // Saturating increment; reaching the limit diverts to lockout
        if (fail_q >= FAIL_W'(MAX_FAIL - 1)) begin
          fail_d  = FAIL_W'(MAX_FAIL);
          state_d = LOCKOUT;
        end else begin
          fail_d  = fail_q + 1'b1;
          state_d = IDLE;
        end
      end
      UNLOCKED: begin
        step_d = '0;
        fail_d = '0;
        cnt_d  = '0;
        if (code_wr) code_d = code_in;
        if (relock)  state_d = IDLE;
      end
      LOCKOUT: begin
        step_d = '0;
        if (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
          state_d = IDLE;
          fail_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    z_d = 2'b00;
    case (state_d)
      ENTRY:         z_d = 2'b01;
      UNLOCKED:      z_d = 2'b10;
      FAIL, LOCKOUT: z_d = 2'b11;
      default:       z_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      z_q     <= 2'b00;
      step_q  <= '0;
      fail_q  <= '0;
      cnt_q   <= '0;
      code_q  <= DEFAULT_CODE;
      sw_q    <= '1;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      step_q  <= step_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      sw_q    <= sw;
    end
  end

  assign state    = state_q;
  assign z        = z_q;
  assign step     = step_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_seq_lock_fsm.sv
// Directed bench for seq_lock_fsm with default parameters: unlock, failure,
// lockout, timeout, reprogramming and mid-entry reset.
module tb_seq_lock_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       relock;
  logic       code_wr;
  logic [7:0] code_in;
  logic [2:0] state;
  logic [1:0] z;
  logic [2:0] step;
  logic [1:0] fail_cnt;

  int vectors     = 0;
  int miscompares = 0;

  seq_lock_fsm #(
    .NUM_SW(4),
    .SEQ_LEN(4),
    .DEFAULT_CODE(8'b11_01_10_00),
    .MAX_FAIL(3),
    .TIMEOUT_CYCLES(256),
    .LOCKOUT_CYCLES(1024)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .relock(relock),
    .code_wr(code_wr),
    .code_in(code_in),
    .state(state),
    .z(z),
    .step(step),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int zz, input int stp, input int fc);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".z"}, 32'(z), 32'(zz));
    chk({tag, ".step"}, 32'(step), 32'(stp));
    chk({tag, ".fail"}, 32'(fail_cnt), 32'(fc));
  endtask

  // Drive a switch value for one edge, then release it for one edge.
  task automatic press(input logic [3:0] v);
    sw = v;
    tick();
  endtask

  task automatic release_sw();
    sw = 4'b0000;
    tick();
  endtask

  initial begin
    reset   = 1'b0;
    sw      = 4'b0000;
    relock  = 1'b0;
    code_wr = 1'b0;
    code_in = 8'h00;
    tick();
    chk_all("reset", 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    chk_all("post_reset", 0, 0, 0, 0);

    // Correct default code: sw0, sw2, sw1, sw3
    press(4'b0001); chk_all("ok1", 1, 1, 1, 0); release_sw();
    press(4'b0100); chk_all("ok2", 1, 1, 2, 0); release_sw();
    press(4'b0010); chk_all("ok3", 1, 1, 3, 0); release_sw();
    press(4'b1000); chk_all("unlock", 2, 2, 0, 0); release_sw();
    press(4'b0001); chk_all("unl_ignore", 2, 2, 0, 0); release_sw();
    relock = 1'b1; tick(); relock = 1'b0;
    chk_all("relock", 0, 0, 0, 0);

    // Wrong second press, switch held through FAIL exit
    press(4'b0001); chk_all("w_entry", 1, 1, 1, 0); release_sw();
    press(4'b0010); chk_all("w_fail", 3, 3, 0, 0);
    tick();         chk_all("w_idle", 0, 0, 0, 1);
    tick();         chk_all("w_held", 0, 0, 0, 1);
    release_sw();

    // Multi-hot press in IDLE
    press(4'b0011); chk_all("mh_fail", 3, 3, 0, 1);
    release_sw();   chk_all("mh_idle", 0, 0, 0, 2);

    // Third failure leads to lockout; presses ignored throughout
    press(4'b0010); chk_all("l_fail", 3, 3, 0, 2);
    release_sw();   chk_all("l_enter", 4, 3, 0, 3);
    for (int i = 1; i < 1024; i++) begin
      sw = ((i % 50) == 10) ? 4'b0001 : 4'b0000;
      tick();
    end
    chk_all("l_last", 4, 3, 0, 3);
    sw = 4'b0000;
    tick();
    chk_all("l_exit", 0, 0, 0, 0);

    // Timeout: last press at edge n, IDLE after edge n+256
    press(4'b0001); chk_all("t_entry", 1, 1, 1, 0);
    release_sw();
    ticks(254);     chk_all("t_255", 1, 1, 1, 0);
    tick();         chk_all("t_256", 0, 0, 0, 0);

    // Press on the expiry cycle wins over the timeout
    press(4'b0001); release_sw();
    ticks(254);
    press(4'b0100); chk_all("t_race", 1, 1, 2, 0); release_sw();
    press(4'b0010); release_sw();
    press(4'b1000); chk_all("unlock2", 2, 2, 0, 0); release_sw();

    // Reprogram together with relock
    code_wr = 1'b1; code_in = 8'b00_01_10_11; relock = 1'b1;
    tick();
    code_wr = 1'b0; relock = 1'b0;
    chk_all("reprog", 0, 0, 0, 0);
    // code_wr outside UNLOCKED must not restore the old code
    code_wr = 1'b1; code_in = 8'b11_01_10_00;
    tick();
    code_wr = 1'b0;
    press(4'b0001); chk_all("old_fail", 3, 3, 0, 0); release_sw();
    chk_all("old_idle", 0, 0, 0, 1);
    press(4'b1000); chk_all("n1", 1, 1, 1, 1); release_sw();
    press(4'b0100); chk_all("n2", 1, 1, 2, 1); release_sw();
    press(4'b0010); chk_all("n3", 1, 1, 3, 1); release_sw();
    press(4'b0001); chk_all("n_unlock", 2, 2, 0, 0); release_sw();
    relock = 1'b1; tick(); relock = 1'b0;

    // Reset mid-entry with switch held
    press(4'b1000); release_sw();
    press(4'b0100); chk_all("r_pre", 1, 1, 2, 0);
    reset = 1'b0;
    tick();
    chk_all("r_mid", 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    chk_all("r_held", 0, 0, 0, 0);
    release_sw();
    // Reset restored the default code
    press(4'b0001); chk_all("r_default", 1, 1, 1, 0); release_sw();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_lock_fsm.md
# seq_lock_fsm

Parametrised switch-sequence lock controller for the lab-board switch inputs. The block detects discrete switch presses, matches them against a programmable code of SEQ_LEN entries, and reports progress, unlock, failure and lockout. Compared with the fixed four-switch sequence FSM, it adds:

- configurable switch count and code length;
- a code that can be reprogrammed while unlocked;
- an entry timeout;
- a failed-attempt counter with timed lockout.

## Interface
- NUM_SW, default 4: number of switch inputs, at least 2; IDX_W = $clog2(NUM_SW).
- SEQ_LEN, default 4: code length in presses, at least 1; STEP_W = $clog2(SEQ_LEN+1).
- DEFAULT_CODE, default 8'b11_01_10_00: code loaded at reset, SEQ_LEN*IDX_W bits. Entry i sits at bits [i*IDX_W +: IDX_W] and is entered i-th. The default is the sequence sw[0], sw[2], sw[1], sw[3].
- MAX_FAIL, default 3: consecutive failures that trigger lockout, at least 1.
- TIMEOUT_CYCLES, default 256: idle cycles allowed between presses in ENTRY.
- LOCKOUT_CYCLES, default 1024: cycles spent in LOCKOUT.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- sw  in  NUM_SW  switch levels, already synchronised and debounced upstream.
- relock  in  1  single-cycle pulse; returns UNLOCKED to IDLE.
- code_wr  in  1  write-enable for a new code.
- code_in  in  SEQ_LEN*IDX_W  new code, same packing as DEFAULT_CODE.
- state  out  3  current state encoding.
- z  out  2  status: 00 idle, 01 entering, 10 unlocked, 11 fail or lockout.
- step  out  STEP_W  number of correct presses so far in the current attempt.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed attempts.

## Operation
- A press event occurs in a cycle where sw != 0 and the previous cycle's registered sw_q == 0.
  - If sw is one-hot, the press index is the position of the set bit.
  - A multi-hot press counts as a wrong entry.
  - Holding a switch produces no further events; it must return to all-zero first.
- A press is correct when it is one-hot and its index equals code entry [step]. Code entries with value >= NUM_SW can never match.
- State encoding: IDLE = 3'b000, ENTRY = 3'b001, UNLOCKED = 3'b010, FAIL = 3'b011, LOCKOUT = 3'b100. Other encodings go to IDLE.
- IDLE, z = 00, step = 0:
  - correct press goes to ENTRY with step = 1, or to UNLOCKED directly if SEQ_LEN == 1;
  - wrong press goes to FAIL.
- ENTRY, z = 01:
  - correct press increments step; when step reaches SEQ_LEN the block moves to UNLOCKED;
  - wrong press goes to FAIL;
  - TIMEOUT_CYCLES consecutive cycles without a press return the block to IDLE with step = 0. A timeout does not count as a failure.
  - The timeout counter clears on every press and on ENTRY entry.
- FAIL, z = 11, always lasts exactly one cycle:
  - step is cleared and fail_cnt increments;
  - if the new fail_cnt equals MAX_FAIL the block goes to LOCKOUT, otherwise to IDLE.
- UNLOCKED, z = 10:
  - fail_cnt and step clear on entry;
  - press events are ignored;
  - code_wr = 1 loads code_in into the code register;
  - relock = 1 returns the block to IDLE.
- LOCKOUT, z = 11:
  - presses are ignored;
  - after LOCKOUT_CYCLES cycles the block goes to IDLE and fail_cnt clears.
- code_wr is ignored in every state except UNLOCKED. relock is ignored in every state except UNLOCKED.

## Timing
- Reset (reset = 0 at an edge) sets:
  - state = IDLE, z = 00, step = 0, fail_cnt = 0;
  - code register = DEFAULT_CODE;
  - sw_q = all-ones, so a switch held through reset is not a press;
  - all timers = 0.
- Reset applies in every state, including mid-entry and mid-lockout.
- All outputs are registered. A press sampled at edge n is reflected in state, z and step after edge n.
- code_wr sampled at edge n: the new code is used for presses from edge n+1 onward.
- Timeout: with the last press at edge n, the block is in IDLE after edge n+TIMEOUT_CYCLES.
- LOCKOUT entered at edge n returns to IDLE after edge n+LOCKOUT_CYCLES.
- Simultaneous events in UNLOCKED:
  - code_wr and relock in the same cycle: the code is written and the state goes to IDLE;
  - press and relock in the same cycle: the press is discarded.
- A press in the same cycle as the timeout expiry is handled as a press; the timeout does not apply.
- A switch still held when LOCKOUT or FAIL exits is not a press until it is released.
- fail_cnt saturates at MAX_FAIL and never wraps.

## Test plan
- Correct code with defaults: press sw = 0001, 0100, 0010, 1000, each separated by an all-zero cycle -> step goes 1, 2, 3, then state = 010, z = 10, fail_cnt = 0.
- Wrong entry: press 0001, then 0010 -> one cycle with state = 011, z = 11, then IDLE with fail_cnt = 1. A multi-hot press of 0011 in IDLE produces the same FAIL result.
- Lockout: three consecutive wrong presses -> state = 100 with fail_cnt = 3. Presses are ignored for 1024 cycles, then the block is in IDLE with fail_cnt = 0.
- Timeout: press 0001, then hold sw = 0 -> still ENTRY with step = 1 after 255 cycles; IDLE with step = 0 and fail_cnt unchanged after 256 cycles.
- Reprogram: while UNLOCKED, assert code_wr with code_in = 8'b00_01_10_11 together with relock -> IDLE. The sequence 1000, 0100, 0010, 0001 then unlocks, and the old code fails at its 1st press.
- Reset mid-operation: pull reset low during ENTRY with step = 2 while sw is held at 0100 -> all outputs at their reset values. Releasing reset with the switch still held produces no press event.
